dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning data-array size in 32-bit words, where the word index is req_addr[9:2].
REQ-002 SHALL have parameter LOAD_LAT, default 2, meaning cycles from load dequeue to resp_valid (legal range 1-7).
REQ-003 SHALL have parameter QDEPTH, default 4, meaning request FIFO entries (power of 2).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset (0 = in reset).
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, FIFO can accept.
REQ-008 SHALL have port req_is_store, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, 32, byte address; bits [1:0] and bits above the index are ignored.
REQ-010 SHALL have port req_wdata, input, 32, store data.
REQ-011 SHALL have port req_pd, input, 7, load destination physical register.
REQ-012 SHALL have port req_rob, input, 5, ROB tag of the request.
REQ-013 SHALL have port rob_head, input, 5, current ROB head, used for age comparison.
REQ-014 SHALL have port mispredict, input, 1, flush strobe.
REQ-015 SHALL have port mispredict_tag, input, 5, ROB tag of the mispredicted branch.
REQ-016 SHALL have port resp_valid, output, 1, load data available.
REQ-017 SHALL have port resp_ready, input, 1, consumer accepts the response.
REQ-018 SHALL have port resp_data, output, 32, loaded word.
REQ-019 SHALL have port resp_pd, output, 7, echoed pd.
REQ-020 SHALL have port resp_rob, output, 5, echoed ROB tag.
REQ-021 SHALL have port store_done, output, 1, one-cycle pulse when a store is written to the array.
REQ-022 SHALL have port store_rob, output, 5, ROB tag of the completed store.

Function
REQ-023 SHALL accept a request when req_valid && req_ready, pushing {is_store, index, wdata, pd, rob, live=1} into the FIFO.
REQ-024 SHALL drive req_ready = (occupancy < QDEPTH) from registered occupancy only; no push when full, even if a pop occurs in the same cycle.
REQ-025 SHALL process entries strictly in FIFO order, one at a time, using FSM states IDLE, WAIT, RESP.
REQ-026 In IDLE with the FIFO non-empty, SHALL pop the head entry in that cycle.
REQ-027 A popped entry with live=0 SHALL be discarded with no other effect, remaining in IDLE.
REQ-028 A popped live store SHALL write the array in the pop cycle and assert store_done/store_rob for exactly the next cycle, remaining in IDLE.
REQ-029 A popped live load SHALL latch pd, rob, and index, load the counter with LOAD_LAT-1, and enter WAIT.
REQ-030 WAIT SHALL decrement the counter each cycle; at 0 it SHALL capture the array word and enter RESP.
REQ-031 With LOAD_LAT=2, resp_valid SHALL rise two cycles after the pop edge.
REQ-032 RESP SHALL hold resp_valid=1 with stable resp_data, resp_pd, and resp_rob until resp_ready=1, then return to IDLE; a pop SHALL NOT occur in that same cycle.
REQ-033 Age SHALL be defined as age(t) = (t - rob_head) mod 32, computed in 5-bit wrap arithmetic.
REQ-034 An entry with tag t SHALL be younger iff age(t) > age(mispredict_tag).
REQ-035 On mispredict=1, SHALL clear live on every younger load in the FIFO.
REQ-036 On mispredict=1, a younger load arriving in the same cycle SHALL be pushed with live=0.
REQ-037 On mispredict=1, a younger load in WAIT or RESP SHALL be aborted: state goes to IDLE next cycle and resp_valid is never asserted for it (or deasserts next cycle).
REQ-038 Stores SHALL never be flushed; loads not younger than mispredict_tag SHALL be unaffected.
REQ-039 The array SHALL be read-after-write consistent: a load popped after a store to the same index returns the stored data.
REQ-040 Each FIFO pointer SHALL be log2(QDEPTH) bits wide and wrap modulo QDEPTH; occupancy SHALL be log2(QDEPTH)+1 bits.

Reset
REQ-041 While reset=0, SHALL force the following: FIFO empty, state IDLE, counter 0, resp_valid=0, resp_data/resp_pd/resp_rob=0, store_done=0, store_rob=0, req_ready=1 once released.
REQ-042 Assertion of reset mid-operation SHALL drop any in-flight load and clear all queued entries without any write to the array.
REQ-043 The data array contents SHALL NOT be reset.

Verification
REQ-044 Store then load: store idx 5 = 0xDEADBEEF (rob 3), then load idx 5 (pd 12, rob 4) -> store_done with store_rob=3, then resp_valid 2 cycles after the load pop with data 0xDEADBEEF, pd 12, rob 4.
REQ-045 Backpressure: hold resp_ready=0 for 5 cycles during RESP -> resp outputs stable throughout; the next FIFO entry is not popped until the handshake completes.
REQ-046 Full: push 4 loads while stalled in RESP -> req_ready=0, and a 5th req_valid is not accepted; after the handshake and one pop, req_ready=1 next cycle.
REQ-047 Flush with wrap: rob_head=30, queued loads with rob 31, 1, 2, mispredict_tag=1 -> only rob 31 and rob 1 produce responses; rob 2 is discarded.
REQ-048 Flush in flight: load rob 6 in WAIT, mispredict with tag 4 and rob_head 0 -> no resp_valid for rob 6, state returns to IDLE; a queued store with rob 7 still writes.
REQ-049 Reset mid-load: drive reset=0 during WAIT -> resp_valid=0 immediately and the FIFO is empty after release.

Source files
------------

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Groups the request, load-response and store-completion signals of the
// data-memory responder.
//   req_*      : request channel (valid/ready handshake, requester -> memory)
//   resp_*     : load response channel (valid/ready handshake, memory -> consumer)
//   store_*    : store completion pulse and its ROB tag
// Modports: master = requester/consumer side, slave = dmem_responder side.
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [6:0]  req_pd;
  logic [4:0]  req_rob;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [6:0]  resp_pd;
  logic [4:0]  resp_rob;
  logic        store_done;
  logic [4:0]  store_rob;

  modport master (
    output req_valid, req_is_store, req_addr, req_wdata, req_pd, req_rob, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_pd, resp_rob, store_done, store_rob
  );

  modport slave (
    input  req_valid, req_is_store, req_addr, req_wdata, req_pd, req_rob, resp_ready,
    output req_ready, resp_valid, resp_data, resp_pd, resp_rob, store_done, store_rob
  );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// In-order data-memory responder: requests are queued in a small FIFO and
// processed one at a time. Stores write the word array and pulse store_done;
// loads wait LOAD_LAT cycles and present a response held until accepted.
// Mispredict flushes younger loads (queued, arriving or in flight).
// Ports:
//   clk            : clock, rising edge
//   reset          : asynchronous active-low reset
//   rob_head       : current ROB head, reference point for age comparison
//   mispredict     : flush strobe
//   mispredict_tag : ROB tag of the mispredicted branch
//   bus            : request / response / store-completion channel (slave)
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LOAD_LAT    = 2,
  parameter int QDEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rob_head,
  input  logic                 mispredict,
  input  logic [4:0]           mispredict_tag,
  dmem_responder_if.slave      bus
);
  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam int PW   = $clog2(QDEPTH);
  localparam logic [PW:0] OCC_FULL = (PW+1)'(QDEPTH);
  localparam logic [2:0]  LAT_INIT = 3'(LOAD_LAT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  // Age is the distance from the ROB head in 5-bit wrap arithmetic.
  function automatic logic is_younger(input logic [4:0] tag, input logic [4:0] head,
                                      input logic [4:0] flush_tag);
    logic [4:0] age_tag;
    logic [4:0] age_flush;
    age_tag   = tag - head;
    age_flush = flush_tag - head;
    return (age_tag > age_flush);
  endfunction

  // FIFO storage
  logic            q_store_q [QDEPTH];
  logic [IDXW-1:0] q_idx_q   [QDEPTH];
  logic [31:0]     q_wdata_q [QDEPTH];
  logic [6:0]      q_pd_q    [QDEPTH];
  logic [4:0]      q_rob_q   [QDEPTH];
  logic            q_live_q  [QDEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     occ_q, occ_d;
  logic            req_ready_q;

  logic [31:0]     mem_q [DEPTH_WORDS];

  state_e          state_q;
  logic [2:0]      cnt_q;
  logic [IDXW-1:0] ld_idx_q;
  logic [6:0]      ld_pd_q;
  logic [4:0]      ld_rob_q;
  logic            resp_valid_q;
  logic [31:0]     resp_data_q;
  logic [6:0]      resp_pd_q;
  logic [4:0]      resp_rob_q;
  logic            store_done_q;
  logic [4:0]      store_rob_q;

  logic            push_s, pop_s;
  logic            head_live_s, in_live_s, flight_kill_s;
  logic [IDXW-1:0] req_idx_s;
  logic            unused_addr_s;

  assign req_idx_s     = bus.req_addr[IDXW+1:2];
  assign unused_addr_s = &{1'b0, bus.req_addr[31:IDXW+2], bus.req_addr[1:0]};

  // Handshake decode, flush qualification of head/incoming/in-flight entries, occupancy next-state
  always_comb begin
    push_s = bus.req_valid && req_ready_q;
    pop_s  = (state_q == ST_IDLE) && (occ_q != '0);
    // A head load that is younger than a same-cycle flush is discarded on pop.
    head_live_s = q_live_q[rd_ptr_q] &&
                  !(mispredict && !q_store_q[rd_ptr_q] &&
                    is_younger(q_rob_q[rd_ptr_q], rob_head, mispredict_tag));
    in_live_s = !(mispredict && !bus.req_is_store &&
                  is_younger(bus.req_rob, rob_head, mispredict_tag));
    flight_kill_s = mispredict && is_younger(ld_rob_q, rob_head, mispredict_tag);
    if (push_s && !pop_s) begin
      occ_d = occ_q + (PW+1)'(1);
    end else if (pop_s && !push_s) begin
      occ_d = occ_q - (PW+1)'(1);
    end else begin
      occ_d = occ_q;
    end
  end

  // Request FIFO: pointers, occupancy, registered ready, entry storage and live-bit flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      req_ready_q <= 1'b1;
      for (int i = 0; i < QDEPTH; i++) begin
        q_store_q[i] <= 1'b0;
        q_idx_q[i]   <= '0;
        q_wdata_q[i] <= 32'h0;
        q_pd_q[i]    <= 7'h0;
        q_rob_q[i]   <= 5'h0;
        q_live_q[i]  <= 1'b0;
      end
    end else begin
      occ_q       <= occ_d;
      req_ready_q <= (occ_d < OCC_FULL);
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (mispredict) begin
        for (int i = 0; i < QDEPTH; i++) begin
          if (!q_store_q[i] && is_younger(q_rob_q[i], rob_head, mispredict_tag)) begin
            q_live_q[i] <= 1'b0;
          end
        end
      end
      // The write slot is never occupied when pushing, so this cannot collide with the flush above.
      if (push_s) begin
        q_store_q[wr_ptr_q] <= bus.req_is_store;
        q_idx_q[wr_ptr_q]   <= req_idx_s;
        q_wdata_q[wr_ptr_q] <= bus.req_wdata;
        q_pd_q[wr_ptr_q]    <= bus.req_pd;
        q_rob_q[wr_ptr_q]   <= bus.req_rob;
        q_live_q[wr_ptr_q]  <= in_live_s;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
    end
  end

  // Data array write port (intentionally not reset)
  always_ff @(posedge clk) begin
    if (pop_s && q_store_q[rd_ptr_q] && q_live_q[rd_ptr_q]) begin
      mem_q[q_idx_q[rd_ptr_q]] <= q_wdata_q[rd_ptr_q];
    end
  end

  // Processing FSM with registered response and store-completion outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      ld_idx_q     <= '0;
      ld_pd_q      <= 7'h0;
      ld_rob_q     <= 5'h0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_pd_q    <= 7'h0;
      resp_rob_q   <= 5'h0;
      store_done_q <= 1'b0;
      store_rob_q  <= 5'h0;
    end else begin
      store_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop_s && head_live_s) begin
            if (q_store_q[rd_ptr_q]) begin
              store_done_q <= 1'b1;
              store_rob_q  <= q_rob_q[rd_ptr_q];
            end else begin
              ld_idx_q <= q_idx_q[rd_ptr_q];
              ld_pd_q  <= q_pd_q[rd_ptr_q];
              ld_rob_q <= q_rob_q[rd_ptr_q];
              cnt_q    <= LAT_INIT;
              state_q  <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (flight_kill_s) begin
            cnt_q   <= 3'd0;
            state_q <= ST_IDLE;
          end else if (cnt_q == 3'd0) begin
            resp_data_q  <= mem_q[ld_idx_q];
            resp_pd_q    <= ld_pd_q;
            resp_rob_q   <= ld_rob_q;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_RESP: begin
          if (flight_kill_s || bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          cnt_q        <= 3'd0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_pd    = resp_pd_q;
  assign bus.resp_rob   = resp_rob_q;
  assign bus.store_done = store_done_q;
  assign bus.store_rob  = store_rob_q;
endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rob_head;
  logic       mispredict;
  logic [4:0] mispredict_tag;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(256), .LOAD_LAT(2), .QDEPTH(4)) dut (
    .clk(clk), .reset(reset), .rob_head(rob_head), .mispredict(mispredict),
    .mispredict_tag(mispredict_tag), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [6:0] pd, input logic [4:0] rob);
    bus.req_valid    = 1'b1;
    bus.req_is_store = st;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_pd       = pd;
    bus.req_rob      = rob;
  endtask

  task automatic wait_resp(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (bus.resp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    if (!got) got = (bus.resp_valid === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    vec_cnt++;
    if ({bus.resp_valid, bus.resp_data, bus.resp_pd, bus.resp_rob, bus.store_done, bus.store_rob}
        !== {1'b0, 32'h0, 7'h0, 5'h0, 1'b0, 5'h0}) begin
      err_cnt++;
      $display("FAIL reset_outputs got v=%b d=%h pd=%h rob=%h sd=%b sr=%h exp all zero",
               bus.resp_valid, bus.resp_data, bus.resp_pd, bus.resp_rob, bus.store_done, bus.store_rob);
    end
    reset = 1'b1;
    step();
    vec_cnt++;
    if (bus.req_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_ready got %b exp 1", bus.req_ready);
    end
  endtask

  task automatic test_store_load();
    drive_req(1'b1, 32'h14, 32'hDEADBEEF, 7'd0, 5'd3);
    step();
    drive_req(1'b0, 32'h14, 32'h0, 7'd12, 5'd4);
    step();
    vec_cnt++;
    if ({bus.store_done, bus.store_rob} !== {1'b1, 5'd3}) begin
      err_cnt++;
      $display("FAIL sl_store_done got %b/%0d exp 1/3", bus.store_done, bus.store_rob);
    end
    bus.req_valid = 1'b0;
    step();
    vec_cnt++;
    if ({bus.store_done, bus.resp_valid} !== 2'b00) begin
      err_cnt++;
      $display("FAIL sl_pulse_end got sd=%b rv=%b exp 0 0", bus.store_done, bus.resp_valid);
    end
    step();
    vec_cnt++;
    if (bus.resp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL sl_early_resp got %b exp 0", bus.resp_valid);
    end
    step();
    vec_cnt++;
    if ({bus.resp_valid, bus.resp_data, bus.resp_pd, bus.resp_rob} !== {1'b1, 32'hDEADBEEF, 7'd12, 5'd4}) begin
      err_cnt++;
      $display("FAIL sl_resp got v=%b d=%h pd=%0d rob=%0d exp 1 deadbeef 12 4",
               bus.resp_valid, bus.resp_data, bus.resp_pd, bus.resp_rob);
    end
    bus.resp_ready = 1'b1;
    step();
    vec_cnt++;
    if (bus.resp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL sl_resp_drop got %b exp 0", bus.resp_valid);
    end
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit got;
    drive_req(1'b0, 32'h14, 32'h0, 7'd20, 5'd5);
    step();
    drive_req(1'b1, 32'h1C, 32'hCAFEF00D, 7'd0, 5'd6);
    step();
    bus.req_valid = 1'b0;
    wait_resp(10, got);
    vec_cnt++;
    if (got !== 1'b1) begin
      err_cnt++;
      $display("FAIL bp_resp_seen got %b exp 1", got);
    end
    for (int i = 0; i < 5; i++) begin
      vec_cnt++;
      if ({bus.resp_valid, bus.resp_data, bus.resp_pd, bus.resp_rob, bus.store_done}
          !== {1'b1, 32'hDEADBEEF, 7'd20, 5'd5, 1'b0}) begin
        err_cnt++;
        $display("FAIL bp_stable[%0d] got v=%b d=%h pd=%0d rob=%0d sd=%b exp 1 deadbeef 20 5 0",
                 i, bus.resp_valid, bus.resp_data, bus.resp_pd, bus.resp_rob, bus.store_done);
      end
      step();
    end
    bus.resp_ready = 1'b1;
    step();
    vec_cnt++;
    if ({bus.resp_valid, bus.store_done} !== 2'b00) begin
      err_cnt++;
      $display("FAIL bp_handshake got rv=%b sd=%b exp 0 0", bus.resp_valid, bus.store_done);
    end
    step();
    vec_cnt++;
    if ({bus.store_done, bus.store_rob} !== {1'b1, 5'd6}) begin
      err_cnt++;
      $display("FAIL bp_store_after got %b/%0d exp 1/6", bus.store_done, bus.store_rob);
    end
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_full();
    bit got;
    drive_req(1'b0, 32'h1C, 32'h0, 7'd30, 5'd8);
    step();
    bus.req_valid = 1'b0;
    wait_resp(10, got);
    for (int k = 0; k < 4; k++) begin
      drive_req(1'b0, 32'h1C, 32'h0, 7'(60 + k), 5'(9 + k));
      step();
    end
    drive_req(1'b0, 32'h1C, 32'h0, 7'd64, 5'd13);
    vec_cnt++;
    if (bus.req_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL full_ready got %b exp 0", bus.req_ready);
    end
    step();
    vec_cnt++;
    if (bus.req_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL full_ready_hold got %b exp 0", bus.req_ready);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    step();
    vec_cnt++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b00) begin
      err_cnt++;
      $display("FAIL full_no_pop_on_hs got rv=%b rdy=%b exp 0 0", bus.resp_valid, bus.req_ready);
    end
    step();
    vec_cnt++;
    if (bus.req_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL full_ready_back got %b exp 1", bus.req_ready);
    end
    for (int k = 0; k < 4; k++) begin
      wait_resp(12, got);
      vec_cnt++;
      if ({got, bus.resp_data, bus.resp_pd, bus.resp_rob} !== {1'b1, 32'hCAFEF00D, 7'(60 + k), 5'(9 + k)}) begin
        err_cnt++;
        $display("FAIL full_resp[%0d] got v=%b d=%h pd=%0d rob=%0d exp 1 cafef00d %0d %0d",
                 k, got, bus.resp_data, bus.resp_pd, bus.resp_rob, 60 + k, 9 + k);
      end
      step();
    end
    wait_resp(12, got);
    vec_cnt++;
    if (got !== 1'b0) begin
      err_cnt++;
      $display("FAIL full_fifth_rejected got resp rob=%0d exp none", bus.resp_rob);
    end
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_flush_wrap();
    bit got;
    logic [4:0] exp_rob [2];
    logic [6:0] exp_pd  [2];
    exp_rob[0] = 5'd31; exp_pd[0] = 7'd40;
    exp_rob[1] = 5'd1;  exp_pd[1] = 7'd41;
    rob_head = 5'd30;
    drive_req(1'b0, 32'h14, 32'h0, 7'd39, 5'd30);
    step();
    bus.req_valid = 1'b0;
    wait_resp(10, got);
    drive_req(1'b0, 32'h14, 32'h0, 7'd40, 5'd31);
    step();
    drive_req(1'b0, 32'h14, 32'h0, 7'd41, 5'd1);
    step();
    drive_req(1'b0, 32'h14, 32'h0, 7'd42, 5'd2);
    step();
    drive_req(1'b0, 32'h14, 32'h0, 7'd43, 5'd3);
    mispredict     = 1'b1;
    mispredict_tag = 5'd1;
    step();
    mispredict    = 1'b0;
    bus.req_valid = 1'b0;
    vec_cnt++;
    if ({bus.resp_valid, bus.resp_rob, bus.resp_pd} !== {1'b1, 5'd30, 7'd39}) begin
      err_cnt++;
      $display("FAIL fw_old_kept got v=%b rob=%0d pd=%0d exp 1 30 39", bus.resp_valid, bus.resp_rob, bus.resp_pd);
    end
    bus.resp_ready = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      wait_resp(12, got);
      vec_cnt++;
      if ({got, bus.resp_rob, bus.resp_pd, bus.resp_data} !== {1'b1, exp_rob[k], exp_pd[k], 32'hDEADBEEF}) begin
        err_cnt++;
        $display("FAIL fw_resp[%0d] got v=%b rob=%0d pd=%0d d=%h exp 1 %0d %0d deadbeef",
                 k, got, bus.resp_rob, bus.resp_pd, bus.resp_data, exp_rob[k], exp_pd[k]);
      end
      step();
    end
    wait_resp(15, got);
    vec_cnt++;
    if (got !== 1'b0) begin
      err_cnt++;
      $display("FAIL fw_flushed_resp got resp rob=%0d exp none", bus.resp_rob);
    end
    bus.resp_ready = 1'b0;
    rob_head = 5'd0;
  endtask

  task automatic test_flush_inflight();
    bit got;
    rob_head = 5'd0;
    drive_req(1'b0, 32'h14, 32'h0, 7'd50, 5'd6);
    step();
    drive_req(1'b1, 32'h20, 32'h0BADF00D, 7'd0, 5'd7);
    step();
    bus.req_valid  = 1'b0;
    mispredict     = 1'b1;
    mispredict_tag = 5'd4;
    step();
    mispredict = 1'b0;
    vec_cnt++;
    if ({bus.resp_valid, bus.store_done} !== 2'b00) begin
      err_cnt++;
      $display("FAIL fi_abort got rv=%b sd=%b exp 0 0", bus.resp_valid, bus.store_done);
    end
    step();
    vec_cnt++;
    if ({bus.resp_valid, bus.store_done, bus.store_rob} !== {1'b0, 1'b1, 5'd7}) begin
      err_cnt++;
      $display("FAIL fi_store got rv=%b sd=%b sr=%0d exp 0 1 7", bus.resp_valid, bus.store_done, bus.store_rob);
    end
    bus.resp_ready = 1'b1;
    wait_resp(8, got);
    vec_cnt++;
    if (got !== 1'b0) begin
      err_cnt++;
      $display("FAIL fi_no_resp got resp rob=%0d exp none", bus.resp_rob);
    end
    drive_req(1'b0, 32'h20, 32'h0, 7'd51, 5'd9);
    step();
    bus.req_valid = 1'b0;
    wait_resp(10, got);
    vec_cnt++;
    if ({got, bus.resp_data, bus.resp_rob} !== {1'b1, 32'h0BADF00D, 5'd9}) begin
      err_cnt++;
      $display("FAIL fi_store_data got v=%b d=%h rob=%0d exp 1 0badf00d 9", got, bus.resp_data, bus.resp_rob);
    end
    step();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset_midload();
    bit got;
    drive_req(1'b0, 32'h14, 32'h0, 7'd52, 5'd10);
    step();
    drive_req(1'b0, 32'h14, 32'h0, 7'd53, 5'd11);
    step();
    drive_req(1'b0, 32'h14, 32'h0, 7'd54, 5'd12);
    step();
    bus.req_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    vec_cnt++;
    if (bus.resp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL rm_immediate got %b exp 0", bus.resp_valid);
    end
    step();
    vec_cnt++;
    if (bus.resp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL rm_held got %b exp 0", bus.resp_valid);
    end
    step();
    reset = 1'b1;
    step();
    vec_cnt++;
    if (bus.req_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL rm_ready got %b exp 1", bus.req_ready);
    end
    bus.resp_ready = 1'b1;
    wait_resp(15, got);
    vec_cnt++;
    if (got !== 1'b0) begin
      err_cnt++;
      $display("FAIL rm_fifo_empty got resp rob=%0d exp none", bus.resp_rob);
    end
    drive_req(1'b0, 32'h14, 32'h0, 7'd55, 5'd13);
    step();
    bus.req_valid = 1'b0;
    wait_resp(10, got);
    vec_cnt++;
    if ({got, bus.resp_data, bus.resp_pd} !== {1'b1, 32'hDEADBEEF, 7'd55}) begin
      err_cnt++;
      $display("FAIL rm_array_kept got v=%b d=%h pd=%0d exp 1 deadbeef 55", got, bus.resp_data, bus.resp_pd);
    end
    step();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_pd       = 7'h0;
    bus.req_rob      = 5'h0;
    bus.resp_ready   = 1'b0;
    rob_head         = 5'd0;
    mispredict       = 1'b0;
    mispredict_tag   = 5'd0;
    reset            = 1'b0;
    test_reset();
    test_store_load();
    test_backpressure();
    test_full();
    test_flush_wrap();
    test_flush_inflight();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
